fmap_row_col_writer: RTL and testbench
======================================

Name: fmap_row_col_writer

Overview:
- Write-side counterpart of the padded column/row read counters.
- Accepts the convolution engine's output pixel stream over a valid/ready handshake and assigns each beat its (row, col) position in an IMG_W x IMG_H output feature map.
- Issues raster-order linear write addresses to the output frame buffer through a stallable write port.
- Reports line and frame completion to the layer controller.

Parameters:
- IMG_W, 640, output columns per row.
- IMG_H, 640, output rows per frame.
- DATA_W, 16, pixel width.
- ADDR_W, 19, write address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; arms the writer for a new frame.
- in_valid  input  1  source has a pixel.
- in_data  input  DATA_W  pixel value.
- in_ready  output  1  writer accepts this cycle; combinational.
- wr_en  output  1  write request to frame buffer; registered.
- wr_addr  output  ADDR_W  linear write address, row*IMG_W+col; registered.
- wr_data  output  DATA_W  write data; registered.
- mem_ready  input  1  frame buffer consumes the request when wr_en && mem_ready.
- col  output  15  column of the next beat to be accepted.
- row  output  15  row of the next beat to be accepted.
- line_done  output  1  one-cycle pulse; the last column of a row was accepted.
- frame_done  output  1  one-cycle pulse; the final write of the frame was consumed.
- busy  output  1  high in WRITE and FLUSH states.
- err_unexp  output  1  sticky; in_valid seen while IDLE.

Behaviour:
- Reset values: state=IDLE; col=0, row=0, addr=0; wr_en=0, wr_addr=0, wr_data=0; line_done=0, frame_done=0, err_unexp=0.
- Reset is honoured mid-frame: any pending write is dropped immediately.

States:
- IDLE
  - in_ready=0.
  - start -> WRITE; clears col, row, addr and err_unexp.
  - in_valid && !start sets err_unexp.
- WRITE
  - in_ready = !wr_en || mem_ready.
  - A beat is accepted when in_valid && in_ready.
  - start is ignored.
- FLUSH
  - Entered on acceptance of the last beat (row==IMG_H-1, col==IMG_W-1).
  - in_ready=0.
  - Stays until the final wr_en is consumed by mem_ready.
  - Then -> IDLE with frame_done=1 for exactly that next cycle.

Output register:
- Accept at cycle N -> wr_en=1 at N+1, with wr_addr=addr and wr_data=in_data sampled at N.
- wr_en, wr_addr and wr_data hold stable while wr_en && !mem_ready.
- wr_en clears after consumption unless a new beat is accepted in the same cycle; this gives back-to-back throughput of 1 beat/cycle.
- Latency from accept to wr_en is 1 cycle.

Counters, advanced on accept:
- col increments each accept.
- At col==IMG_W-1: col wraps to 0, row increments, and line_done pulses the next cycle.
- At the last beat of the frame: row and col wrap to 0.
- addr increments by 1 each accept and returns to 0 at frame end.
- No multiplier is used.
- Counter widths are sized so IMG_W-1 and IMG_H-1 never overflow.

Boundary conditions:
- The final line_done and the FLUSH entry occur together.
- frame_done never asserts before the last write is consumed.
- mem_ready held low indefinitely stalls the writer without losing or duplicating data.
- A start pulse coinciding with frame_done is legal; it re-arms immediately.

Test Plan:
- IMG_W=4, IMG_H=3, mem_ready=1, start then 12 continuous beats with data 0..11 -> wr_addr 0..11 on consecutive cycles with wr_data=addr; line_done after beats 3, 7, 11; frame_done 1 cycle after the write of addr 11; busy falls with it.
- Same config, mem_ready low for 3 cycles while wr_addr=5 -> in_ready=0 and wr_addr/wr_data hold at 5; exactly one write of addr 5; next write is addr 6.
- Source gaps: in_valid toggled 1,0,1,0 -> addresses stay contiguous, wr_en low in the gap cycles, col increments only on accepts.
- in_valid=1 in IDLE before start -> err_unexp=1 with no writes issued; next start clears it to 0.
- reset asserted mid-frame at addr 7 -> all outputs 0 immediately; after start, the first write is at addr 0.
- Default 640x640, full frame with mem_ready randomised at 50% -> 409600 writes; last wr_addr=409599; exactly 640 line_done pulses and 1 frame_done pulse.

Source files
------------

// File: rtl/fmap_row_col_writer.sv
// Output feature-map writer: tags each accepted pixel with its (row, col)
// and issues raster-order linear writes through a stallable output register.
module fmap_row_col_writer #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 640,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              mem_ready,
    output logic [14:0]       col,
    output logic [14:0]       row,
    output logic              line_done,
    output logic              frame_done,
    output logic              busy,
    output logic              err_unexp
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FLUSH
    } state_t;

    localparam logic [14:0] LAST_COL = 15'(IMG_W - 1);
    localparam logic [14:0] LAST_ROW = 15'(IMG_H - 1);

    state_t              r_state;
    state_t              w_next;
    logic [14:0]         r_col;
    logic [14:0]         r_row;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_line_done;
    logic                r_frame_done;
    logic                r_err;

    logic w_in_ready;
    logic w_acc;
    logic w_last_col;
    logic w_last_beat;
    logic w_start_ok;
    logic w_consume;

    assign w_in_ready  = (r_state == S_WRITE) && (!r_wr_en || mem_ready);
    assign w_acc       = in_valid && w_in_ready;
    assign w_last_col  = (r_col == LAST_COL);
    assign w_last_beat = w_last_col && (r_row == LAST_ROW);
    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_consume   = r_wr_en && mem_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: flush holds until the final write drains
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_WRITE;
            S_WRITE: if (w_acc && w_last_beat) w_next = S_FLUSH;
            S_FLUSH: if (w_consume) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Position counters and running linear address, no multiplier needed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (w_start_ok) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (w_acc) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_beat ? 15'd0 : r_row + 15'd1;
            end else begin
                r_col <= r_col + 15'd1;
            end
            r_addr <= w_last_beat ? '0 : r_addr + 1'b1;
        end
    end

    // Output register: load on accept, hold while stalled, drop once consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_acc) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= in_data;
        end else if (mem_ready) begin
            r_wr_en   <= 1'b0;
        end
    end

    // Status pulses and sticky protocol error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_line_done  <= w_acc && w_last_col;
            r_frame_done <= (r_state == S_FLUSH) && w_consume;
            if (w_start_ok)
                r_err <= 1'b0;
            else if ((r_state == S_IDLE) && in_valid)
                r_err <= 1'b1;
        end
    end

    assign in_ready   = w_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign col        = r_col;
    assign row        = r_row;
    assign line_done  = r_line_done;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != S_IDLE);
    assign err_unexp  = r_err;

endmodule

// File: tb/tb_fmap_row_col_writer.sv
// Directed bench for fmap_row_col_writer on a 4x3 map with a
// beat-count reference model checked every cycle.
module tb_fmap_row_col_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 0;
    logic          reset = 0;
    logic          start = 0;
    logic          in_valid = 0;
    logic [DW-1:0] in_data = '0;
    logic          mem_ready = 1;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [14:0]   col;
    logic [14:0]   row;
    logic          line_done;
    logic          frame_done;
    logic          busy;
    logic          err_unexp;

    fmap_row_col_writer #(
        .IMG_W(W), .IMG_H(H), .DATA_W(DW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_ready(mem_ready), .col(col), .row(row),
        .line_done(line_done), .frame_done(frame_done),
        .busy(busy), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // reference model: frame position is just the count of accepted beats
    int m_mode = 0;
    int m_k = 0;
    int m_paddr = 0;
    int m_pdata = 0;
    bit m_pend = 0;
    bit m_err = 0;
    bit m_line = 0;
    bit m_fd = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_line = 0;
    int n_fd = 0;
    int w_last_cyc = 0;
    int fd_cyc = 0;
    int wlog[$];
    int dlog[$];
    bit rnd_en = 0;

    always @(negedge clk) begin
        bit rdy, acc, cons;
        cyc++;
        if (reset) begin
            m_mode = 0; m_k = 0; m_pend = 0;
            m_err = 0; m_line = 0; m_fd = 0;
        end
        rdy = (m_mode == 1) && (!m_pend || mem_ready);
        chk("in_ready", int'(in_ready), int'(rdy));
        chk("wr_en", int'(wr_en), int'(m_pend));
        if (m_pend) begin
            chk("wr_addr", int'(wr_addr), m_paddr);
            chk("wr_data", int'(wr_data), m_pdata);
        end
        chk("col", int'(col), m_k % W);
        chk("row", int'(row), m_k / W);
        chk("line_done", int'(line_done), int'(m_line));
        chk("frame_done", int'(frame_done), int'(m_fd));
        chk("busy", int'(busy), int'(m_mode != 0));
        chk("err_unexp", int'(err_unexp), int'(m_err));
        if (line_done) n_line++;
        if (frame_done) begin n_fd++; fd_cyc = cyc; end
        if (!reset) begin
            acc  = rdy && in_valid;
            cons = m_pend && mem_ready;
            if (cons) begin
                wlog.push_back(m_paddr);
                dlog.push_back(m_pdata);
                n_wr++;
                if (m_paddr == W*H-1) w_last_cyc = cyc;
            end
            m_line = acc && (m_k % W == W-1);
            m_fd   = (m_mode == 2) && cons;
            case (m_mode)
                0: begin
                    if (start) begin m_mode = 1; m_k = 0; m_err = 0; end
                    else if (in_valid) m_err = 1;
                end
                1: begin
                    if (acc) begin
                        m_pend = 1; m_paddr = m_k; m_pdata = int'(in_data);
                        m_k++;
                        if (m_k == W*H) begin m_k = 0; m_mode = 2; end
                    end else if (cons) m_pend = 0;
                end
                default: begin
                    if (cons) begin m_pend = 0; m_mode = 0; end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_en) mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic send_beat(input int d);
        bit ok;
        int n;
        n = 0;
        in_valid = 1;
        in_data = DW'(d);
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 200);
        if (!ok) chk("beat_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin tick(); n++; end
        chk("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, cnt5, idx5, nw0, nl0, nf0, n;
        #1 reset = 1;
        #1;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) tick();
        reset = 0;
        tick();

        // continuous frame, data equals beat index
        do_start();
        for (int i = 0; i < W*H; i++) send_beat(i);
        in_valid = 0;
        wait_idle();
        tick();
        chk("f1_writes", n_wr, 12);
        for (int i = 0; i < 12; i++) begin
            chk("f1_addr", wlog[i], i);
            chk("f1_data", dlog[i], i);
        end
        chk("f1_lines", n_line, 3);
        chk("f1_frames", n_fd, 1);
        chk("f1_fd_lat", fd_cyc - w_last_cyc, 1);

        // three-cycle stall while addr 5 is pending
        base = wlog.size();
        do_start();
        for (int i = 0; i < 6; i++) send_beat(i);
        mem_ready = 0;
        in_valid = 1;
        in_data = 16'd6;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_rdy", int'(in_ready), 0);
            chk("stall_addr", int'(wr_addr), 5);
            chk("stall_data", int'(wr_data), 5);
            tick();
        end
        mem_ready = 1;
        for (int i = 6; i < W*H; i++) send_beat(i);
        in_valid = 0;
        wait_idle();
        cnt5 = 0;
        idx5 = 0;
        for (int i = base; i < wlog.size(); i++)
            if (wlog[i] == 5) begin cnt5++; idx5 = i; end
        chk("stall_once", cnt5, 1);
        chk("stall_next", wlog[idx5+1], 6);
        chk("stall_total", wlog.size() - base, 12);

        // source gaps
        base = wlog.size();
        do_start();
        for (int i = 0; i < W*H; i++) begin
            send_beat(100 + i);
            in_valid = 0;
            tick();
        end
        wait_idle();
        for (int i = 0; i < 12; i++) begin
            chk("gap_addr", wlog[base+i], i);
            chk("gap_data", dlog[base+i], 100 + i);
        end

        // unexpected valid while idle
        tick();
        nw0 = n_wr;
        in_valid = 1;
        tick();
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("err_set", int'(err_unexp), 1);
        chk("err_nowr", n_wr, nw0);
        tick();
        do_start();
        @(negedge clk);
        chk("err_clr", int'(err_unexp), 0);
        tick();

        // reset in the middle of a frame
        for (int i = 0; i < 8; i++) send_beat(i);
        in_valid = 0;
        chk("pre_rst_addr", int'(wr_addr), 7);
        #1 reset = 1;
        #1;
        chk("mrst_wr_en", int'(wr_en), 0);
        chk("mrst_addr", int'(wr_addr), 0);
        chk("mrst_data", int'(wr_data), 0);
        chk("mrst_col", int'(col), 0);
        chk("mrst_busy", int'(busy), 0);
        tick();
        reset = 0;
        tick();
        base = wlog.size();
        do_start();
        for (int i = 0; i < W*H; i++) send_beat(50 + i);
        in_valid = 0;
        wait_idle();
        chk("mrst_first", wlog[base], 0);
        chk("mrst_count", wlog.size() - base, 12);

        // random back-pressure, back-to-back frames restarted on frame_done
        tick();
        base = wlog.size();
        nl0 = n_line;
        nf0 = n_fd;
        rnd_en = 1;
        do_start();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < W*H; i++) send_beat(i * 3 + f);
            in_valid = 0;
            if (f < 2) begin
                n = 0;
                while (!frame_done && n < 300) begin tick(); n++; end
                chk("fd_timeout", int'(frame_done), 1);
                start = 1;
                tick();
                start = 0;
            end else begin
                wait_idle();
            end
        end
        rnd_en = 0;
        mem_ready = 1;
        tick();
        tick();
        chk("rnd_writes", wlog.size() - base, 36);
        chk("rnd_lines", n_line - nl0, 9);
        chk("rnd_frames", n_fd - nf0, 3);
        for (int i = 0; i < 36; i++) begin
            chk("rnd_addr", wlog[base+i], i % 12);
            chk("rnd_data", dlog[base+i], (i % 12) * 3 + i / 12);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
